// File: rtl/mod_m_tick_bank_if.sv
// Control and status bundle for the mod-M tick bank.
// Per-channel fields are packed with channel i at [i*M_BITS +: M_BITS].
interface mod_m_tick_bank_if #(
    parameter int M_BITS   = 8,
    parameter int CHANNELS = 4
);
    logic                         sync_clr;
    logic [CHANNELS-1:0]          en;
    logic [CHANNELS-1:0]          start;
    logic [CHANNELS-1:0]          oneshot;
    logic [CHANNELS*M_BITS-1:0]   m;
    logic [CHANNELS-1:0]          max_tick;
    logic [CHANNELS-1:0]          busy;
    logic [CHANNELS*M_BITS-1:0]   q;

    modport master (
        output sync_clr, en, start, oneshot, m,
        input  max_tick, busy, q
    );

    modport slave (
        input  sync_clr, en, start, oneshot, m,
        output max_tick, busy, q
    );
endinterface

// File: rtl/mod_m_tick_bank.sv
// Bank of independent programmable mod-M counters with registered wrap ticks.
// Each channel runs continuous or one-shot, sharing only the bank clear.
module mod_m_tick_bank #(
    parameter int M_BITS   = 8,
    parameter int CHANNELS = 4
) (
    input  logic clk,
    input  logic reset,
    mod_m_tick_bank_if.slave bus
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [M_BITS-1:0] ZERO = '0;
    localparam logic [M_BITS-1:0] ONE  = M_BITS'(1);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [M_BITS-1:0] r_reg, r_next;
        logic [M_BITS-1:0] m_reg, m_next;
        logic              tick_reg, tick_next;
        state_t            state, state_next;
        logic [M_BITS-1:0] m_in;
        logic              en_i, start_i, oneshot_i;
        logic              last;

        assign m_in      = bus.m[i*M_BITS +: M_BITS];
        assign en_i      = bus.en[i];
        assign start_i   = bus.start[i];
        assign oneshot_i = bus.oneshot[i];
        // m_reg==0 is filtered out before this compare is used
        assign last      = (r_reg == m_reg - ONE);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_reg    <= '0;
                m_reg    <= '0;
                tick_reg <= 1'b0;
                state    <= IDLE;
            end else begin
                r_reg    <= r_next;
                m_reg    <= m_next;
                tick_reg <= tick_next;
                state    <= state_next;
            end
        end

        always_comb begin
            r_next     = r_reg;
            m_next     = m_reg;
            tick_next  = 1'b0;
            state_next = state;
            if (bus.sync_clr) begin
                r_next     = '0;
                m_next     = m_in;
                state_next = IDLE;
            end else if (m_in != m_reg) begin
                m_next = m_in;
                r_next = '0;
                if (m_in == ZERO)
                    state_next = IDLE;
            end else if (m_reg == ZERO) begin
                r_next     = '0;
                state_next = IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (oneshot_i ? start_i : en_i) begin
                            state_next = RUN;
                            r_next     = '0;
                        end
                    end
                    RUN: begin
                        if (oneshot_i && start_i) begin
                            r_next = '0;
                        end else if (en_i) begin
                            if (last) begin
                                r_next    = '0;
                                tick_next = 1'b1;
                                if (oneshot_i)
                                    state_next = IDLE;
                            end else begin
                                r_next = r_reg + ONE;
                            end
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end
        end

        assign bus.q[i*M_BITS +: M_BITS] = r_reg;
        assign bus.max_tick[i]           = tick_reg;
        assign bus.busy[i]               = (state == RUN);
    end

endmodule

// File: tb/tb_mod_m_tick_bank.sv
// Randomized scoreboard bench for the mod-M tick bank.
// A behavioural model predicts each cycle; a monitor compares after each edge.
module tb_mod_m_tick_bank;
    localparam int MB = 8;
    localparam int CH = 4;

    logic clk = 1'b0;
    logic reset;

    mod_m_tick_bank_if #(.M_BITS(MB), .CHANNELS(CH)) bus ();

    mod_m_tick_bank #(.M_BITS(MB), .CHANNELS(CH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH*MB-1:0] q;
        logic [CH-1:0]    t;
        logic [CH-1:0]    b;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int checks   = 0;
    int failures = 0;

    int cnt[CH];
    int mod[CH];
    bit run[CH];
    bit tk[CH];

    logic            sc;
    logic [CH-1:0]   en, st, os;
    logic [CH*MB-1:0] mv;

    function automatic void chk(string name, logic [63:0] act,
                                logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < CH; i++) begin
            cnt[i] = 0;
            mod[i] = 0;
            run[i] = 0;
            tk[i]  = 0;
        end
    endfunction

    // Channel behaviour from the rules: count modulo the latched modulus,
    // tick when the count comes back round to zero.
    function automatic void model_step();
        for (int i = 0; i < CH; i++) begin
            int mi;
            mi = int'(mv[i*MB +: MB]);
            tk[i] = 0;
            if (sc) begin
                cnt[i] = 0;
                run[i] = 0;
                mod[i] = mi;
            end else if (mi != mod[i]) begin
                mod[i] = mi;
                cnt[i] = 0;
                if (mi == 0) run[i] = 0;
            end else if (mod[i] == 0) begin
                cnt[i] = 0;
                run[i] = 0;
            end else if (!run[i]) begin
                if (os[i] ? st[i] : en[i]) begin
                    run[i] = 1;
                    cnt[i] = 0;
                end
            end else if (os[i] && st[i]) begin
                cnt[i] = 0;
            end else if (en[i]) begin
                cnt[i] = (cnt[i] + 1) % mod[i];
                if (cnt[i] == 0) begin
                    tk[i] = 1;
                    if (os[i]) run[i] = 0;
                end
            end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t x;
        for (int i = 0; i < CH; i++) begin
            x.q[i*MB +: MB] = MB'(cnt[i]);
            x.t[i]          = tk[i];
            x.b[i]          = run[i];
        end
        return x;
    endfunction

    task automatic cycle();
        @(negedge clk);
        reset       = 1'b1;
        bus.sync_clr = sc;
        bus.en      = en;
        bus.start   = st;
        bus.oneshot = os;
        bus.m       = mv;
        model_step();
        sb.push_back(model_out());
    endtask

    function automatic logic [MB-1:0] pick_m();
        unique case ($urandom_range(7))
            0: return 8'd0;
            1: return 8'd1;
            2: return 8'd255;
            3: return 8'd8;
            default: return MB'($urandom_range(2, 12));
        endcase
    endfunction

    task automatic run_random(int n, int p_mchg, int p_pause,
                              int p_start, int p_sync, bit toggle);
        repeat (n) begin
            sc = ($urandom_range(999) < p_sync);
            for (int i = 0; i < CH; i++) begin
                en[i] = ($urandom_range(99) >= p_pause);
                st[i] = ($urandom_range(99) < p_start);
                if (toggle && $urandom_range(99) < 2)
                    os[i] = ~os[i];
                if ($urandom_range(999) < p_mchg)
                    mv[i*MB +: MB] = pick_m();
            end
            cycle();
        end
    endtask

    task automatic check_reset_state(string tag);
        chk({tag, "_q"},    64'(bus.q),        64'd0);
        chk({tag, "_tick"}, 64'(bus.max_tick), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy),     64'd0);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("q",        64'(bus.q),        64'(e.q));
            chk("max_tick", 64'(bus.max_tick), 64'(e.t));
            chk("busy",     64'(bus.busy),     64'(e.b));
        end
    end

    initial begin
        reset        = 1'b0;
        sc           = 1'b0;
        en           = '0;
        st           = '0;
        os           = '0;
        mv           = '0;
        bus.sync_clr = 1'b0;
        bus.en       = '0;
        bus.start    = '0;
        bus.oneshot  = '0;
        bus.m        = '0;
        model_reset();
        #1;
        check_reset_state("reset_init");
        repeat (2) @(posedge clk);

        // ch0 m=5, ch1 m=1, ch2 one-shot m=4, ch3 m=255 with steady enable
        os = 4'b0100;
        mv = {8'd255, 8'd4, 8'd1, 8'd5};
        run_random(700, 0, 0, 3, 0, 1'b0);

        run_random(3000, 20, 15, 5, 5, 1'b1);

        // Staggered phases then a bank clear aligns all channels
        os = '0;
        en = '1;
        st = '0;
        sc = 1'b0;
        mv = {8'd8, 8'd8, 8'd8, 8'd8};
        cycle();
        en = 4'b0001;
        repeat (3) cycle();
        en = 4'b0011;
        repeat (2) cycle();
        en = '1;
        repeat (5) cycle();
        sc = 1'b1;
        cycle();
        sc = 1'b0;
        repeat (40) cycle();

        // Asynchronous reset while counting
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_reset_state("reset_mid");
        model_reset();
        @(posedge clk);

        run_random(400, 20, 10, 5, 5, 1'b1);

        // Disabled channels ignore start and enable
        mv = '0;
        en = '1;
        st = '1;
        os = 4'b1010;
        repeat (20) cycle();

        begin
            int guard = 0;
            @(negedge clk);
            while (sb.size() > 0 && guard < 10) begin
                @(negedge clk);
                guard++;
            end
            checks++;
            if (sb.size() > 0) begin
                failures++;
                $display("FAIL drain actual=%0d required=0", sb.size());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
